// File: rtl/regfile_mp_if.sv
// Bundle of read, write and dump-stream signals for the multi-port register file.
// The master side drives the requests, and the slave side is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     dump_start;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [ADDR_W-1:0]        dump_addr;
  logic [DATA_W-1:0]        dump_data;
  logic                     dump_busy;
  logic                     dump_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    input  rd_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    output rd_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the MIPS datapath.
// Each read port is combinational. Register 0 can optionally be hardwired to zero.
// A read of the address being written in the same cycle can optionally return the
// write data (write-to-read bypass).
// A valid/ready dump engine streams every register out, one beat per accepted transfer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  logic [DATA_W-1:0] regs [DEPTH];
  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [DATA_W-1:0] dump_q;
  logic              accept;
  logic              wr_allowed;

  // Read of one address as seen this cycle.
  // The zero register takes priority over the bypass path.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG != 0 && addr == '0)
      return '0;
    if (BYPASS != 0 && bus.wr_en && bus.wr_addr == addr)
      return bus.wr_data;
    return regs[addr];
  endfunction

  assign wr_allowed = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign accept     = (state == SEND) && bus.dump_ready;
  assign idx_next   = idx + 1'b1;

  // Register array: reset clears every entry, and a write in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_allowed) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Independent combinational read ports, packed side by side.
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++)
      bus.rd_data[k*DATA_W +: DATA_W] = read_port(bus.rd_addr[k*ADDR_W +: ADDR_W]);
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Dump FSM next state. A start request outside IDLE is dropped and is not queued.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.dump_start) next_state = SEND;
      SEND:    if (accept && idx == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat index and captured beat data.
  // The data is captured at the accept edge, so it stays stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      dump_q <= '0;
    end else if (state == IDLE && bus.dump_start) begin
      idx    <= '0;
      dump_q <= read_port('0);
    end else if (accept && idx != LAST_IDX) begin
      idx    <= idx_next;
      dump_q <= read_port(idx_next);
    end
  end

  assign bus.dump_valid = (state == SEND);
  assign bus.dump_busy  = (state != IDLE);
  assign bus.dump_done  = (state == DONE);
  assign bus.dump_addr  = idx;
  assign bus.dump_data  = dump_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp.
// The main instance uses 4 read ports with the zero register and bypass enabled.
// The alternate instance uses 2 read ports with the zero register and bypass disabled.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_alt ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk (clk),
    .rst (rst),
    .bus (bus_alt)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value with its expected value and counts a failure on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives the same write request into both instances.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus_alt.wr_en   = we;
    bus_alt.wr_addr = wa;
    bus_alt.wr_data = wd;
  endtask

  // Points every read port of both instances at one address.
  task automatic setReadAll(input logic [4:0] a);
    bus.rd_addr     = {4{a}};
    bus_alt.rd_addr = {2{a}};
  endtask

  // Advances to just after the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mainRd(input int k);
    return bus.rd_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] altRd(input int k);
    return bus_alt.rd_data[k*32 +: 32];
  endfunction

  // Directed test sequence.
  initial begin
    logic [31:0] exp_main;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0);
    setReadAll(5'd0);
    bus.dump_start     = 1'b0;
    bus.dump_ready     = 1'b0;
    bus_alt.dump_start = 1'b0;
    bus_alt.dump_ready = 1'b0;

    // Put data in r3 first so that reset has something to clear.
    applyStimulus(1'b1, 5'd3, 32'h0000_0055);
    stepClock();

    // Reset is held for one cycle. A write to r4 in the same cycle must be dropped.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd4, 32'h0000_0066);
    stepClock();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("reset_valid", 32'(bus.dump_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.dump_busy), 32'd0);
    checkOutput("reset_done", 32'(bus.dump_done), 32'd0);
    checkOutput("reset_addr", 32'(bus.dump_addr), 32'd0);
    checkOutput("reset_data", bus.dump_data, 32'd0);
    checkOutput("reset_alt_valid", 32'(bus_alt.dump_valid), 32'd0);
    checkOutput("reset_alt_busy", 32'(bus_alt.dump_busy), 32'd0);
    for (int a = 0; a < 32; a++) begin
      setReadAll(5'(a));
      #1;
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("reset_rd a%0d p%0d", a, k), mainRd(k), 32'd0);
      for (int k = 0; k < 2; k++)
        checkOutput($sformatf("reset_alt_rd a%0d p%0d", a, k), altRd(k), 32'd0);
    end
    stepClock();

    // Write r5 while reading it in the same cycle, then read it again after the edge.
    setReadAll(5'd5);
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("bypass_main p%0d", k), mainRd(k), 32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("nobypass_alt p%0d", k), altRd(k), 32'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("after_write_main", mainRd(0), 32'hDEAD_BEEF);
    checkOutput("after_write_alt", altRd(0), 32'hDEAD_BEEF);

    // Writes to r0 are ignored and r0 reads as zero only in the main instance.
    setReadAll(5'd0);
    applyStimulus(1'b1, 5'd0, 32'h1234_5678);
    #1;
    checkOutput("zero_over_bypass", mainRd(1), 32'd0);
    checkOutput("zero_alt_old", altRd(0), 32'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0);
    #1;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("zero_main p%0d", k), mainRd(k), 32'd0);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("zero_alt p%0d", k), altRd(k), 32'h1234_5678);

    // Preload r_i = 0x100 + i. In the main instance r0 stays zero.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i));
      stepClock();
    end
    applyStimulus(1'b0, 5'd0, 32'd0);
    setReadAll(5'd31);
    #1;
    checkOutput("preload_r31", mainRd(3), 32'h0000_011F);

    // Full-rate dump on both instances. A second start request mid-stream is ignored.
    bus.dump_ready     = 1'b1;
    bus_alt.dump_ready = 1'b1;
    bus.dump_start     = 1'b1;
    bus_alt.dump_start = 1'b1;
    stepClock();
    bus.dump_start     = 1'b0;
    bus_alt.dump_start = 1'b0;
    for (int b = 0; b < 32; b++) begin
      exp_main = (b == 0) ? 32'd0 : 32'h100 + 32'(b);
      checkOutput($sformatf("full_valid b%0d", b), 32'(bus.dump_valid), 32'd1);
      checkOutput($sformatf("full_addr b%0d", b), 32'(bus.dump_addr), 32'(b));
      checkOutput($sformatf("full_data b%0d", b), bus.dump_data, exp_main);
      checkOutput($sformatf("full_busy b%0d", b), 32'(bus.dump_busy), 32'd1);
      checkOutput($sformatf("full_done b%0d", b), 32'(bus.dump_done), 32'd0);
      checkOutput($sformatf("full_alt_addr b%0d", b), 32'(bus_alt.dump_addr), 32'(b));
      checkOutput($sformatf("full_alt_data b%0d", b), bus_alt.dump_data, 32'h100 + 32'(b));
      bus.dump_start     = (b == 15);
      bus_alt.dump_start = (b == 15);
      stepClock();
    end
    bus.dump_start     = 1'b0;
    bus_alt.dump_start = 1'b0;
    checkOutput("full_end_valid", 32'(bus.dump_valid), 32'd0);
    checkOutput("full_end_done", 32'(bus.dump_done), 32'd1);
    checkOutput("full_end_busy", 32'(bus.dump_busy), 32'd1);
    checkOutput("full_end_alt_done", 32'(bus_alt.dump_done), 32'd1);
    stepClock();
    checkOutput("full_idle_done", 32'(bus.dump_done), 32'd0);
    checkOutput("full_idle_busy", 32'(bus.dump_busy), 32'd0);
    checkOutput("full_idle_valid", 32'(bus.dump_valid), 32'd0);
    checkOutput("full_idle_alt_busy", 32'(bus_alt.dump_busy), 32'd0);
    stepClock();
    checkOutput("no_queued_start", 32'(bus.dump_busy), 32'd0);

    // Backpressure on the main instance, with dump_ready going 1, 0, 0, 1.
    bus_alt.dump_ready = 1'b0;
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b1;
    stepClock();
    bus.dump_start = 1'b0;
    checkOutput("bp_first_valid", 32'(bus.dump_valid), 32'd1);
    checkOutput("bp_first_addr", 32'(bus.dump_addr), 32'd0);
    checkOutput("bp_first_data", bus.dump_data, 32'd0);
    bus.dump_ready = 1'b1;
    stepClock();
    checkOutput("bp_beat1_addr", 32'(bus.dump_addr), 32'd1);
    checkOutput("bp_beat1_data", bus.dump_data, 32'h0000_0101);
    bus.dump_ready = 1'b0;
    applyStimulus(1'b1, 5'd1, 32'h0000_AAAA);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0);
    setReadAll(5'd1);
    #1;
    checkOutput("bp_stall_data", bus.dump_data, 32'h0000_0101);
    checkOutput("bp_stall_addr", 32'(bus.dump_addr), 32'd1);
    checkOutput("bp_stall_valid", 32'(bus.dump_valid), 32'd1);
    checkOutput("bp_reg_written", mainRd(2), 32'h0000_AAAA);
    stepClock();
    checkOutput("bp_stall2_data", bus.dump_data, 32'h0000_0101);
    bus.dump_ready = 1'b1;
    applyStimulus(1'b1, 5'd2, 32'h0000_BBBB);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'd0);
    checkOutput("bp_next_addr", 32'(bus.dump_addr), 32'd2);
    checkOutput("bp_next_bypass", bus.dump_data, 32'h0000_BBBB);
    repeat (8) stepClock();
    checkOutput("bp_beat10_addr", 32'(bus.dump_addr), 32'd10);
    checkOutput("bp_beat10_data", bus.dump_data, 32'h0000_010A);

    // Reset during beat 10 aborts the dump without a done pulse.
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("abort_valid", 32'(bus.dump_valid), 32'd0);
    checkOutput("abort_busy", 32'(bus.dump_busy), 32'd0);
    checkOutput("abort_done", 32'(bus.dump_done), 32'd0);
    checkOutput("abort_addr", 32'(bus.dump_addr), 32'd0);
    checkOutput("abort_data", bus.dump_data, 32'd0);
    for (int c = 0; c < 3; c++) begin
      stepClock();
      checkOutput($sformatf("abort_no_done c%0d", c), 32'(bus.dump_done), 32'd0);
    end
    for (int a = 0; a < 32; a++) begin
      setReadAll(5'(a));
      #1;
      checkOutput($sformatf("abort_rd a%0d", a), mainRd(a % 4), 32'd0);
      checkOutput($sformatf("abort_alt_rd a%0d", a), altRd(a % 2), 32'd0);
    end
    stepClock();

    // A start request on the same edge as reset is ignored.
    rst = 1'b1;
    bus.dump_start = 1'b1;
    stepClock();
    rst = 1'b0;
    bus.dump_start = 1'b0;
    checkOutput("rst_start_busy", 32'(bus.dump_busy), 32'd0);
    checkOutput("rst_start_valid", 32'(bus.dump_valid), 32'd0);

    // A fresh start restarts from address 0 and runs to completion within a bounded wait.
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b1;
    stepClock();
    bus.dump_start = 1'b0;
    checkOutput("restart_valid", 32'(bus.dump_valid), 32'd1);
    checkOutput("restart_addr", 32'(bus.dump_addr), 32'd0);
    checkOutput("restart_busy", 32'(bus.dump_busy), 32'd1);
    bus.dump_ready = 1'b1;
    for (int c = 0; c < 40 && !bus.dump_done; c++)
      stepClock();
    checkOutput("restart_done", 32'(bus.dump_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
